uart_word_loader: RTL and testbench
===================================

// Module: uart_word_loader
// PURPOSE
//   Receive side of the boot loader. Deserialises 8-bit UART frames from Rx_Serial and packs every 4 bytes into a 32-bit word.
//   Each word is presented to the memory bus as a one-cycle write strobe with a word address, filling instruction RAM or data RAM.
//   Sits between the board Rx pin and the IM/DM write ports; its outputs drive on_received, recv_data, addr, IM_Done and DM_Done.
// PARAMETERS
//   CLKS_PER_BIT  868  clk cycles per UART bit (100 MHz / 115200)
//   IM_SIZE       256  instruction RAM depth, in words
//   DM_SIZE       512  data RAM depth, in words
//   ADDR_BIT      9    addr width; must satisfy 2**ADDR_BIT >= max(IM_SIZE, DM_SIZE)
// PORTS
//   clk          in   1         system clock, all logic on rising edge
//   reset        in   1         asynchronous, active-high; clears all state
//   en           in   1         loader enable; high while a load is in progress
//   ram_id       in   1         0 = load IM, 1 = load DM; latched on rising edge of en
//   Rx_Serial    in   1         UART line, idles high
//   addr         out  ADDR_BIT  word index of the current/next write
//   on_received  out  1         one-cycle write strobe; recv_data and addr are valid in that cycle
//   recv_data    out  32        assembled word
//   IM_Done      out  1         sticky: IM completely loaded
//   DM_Done      out  1         sticky: DM completely loaded
//   frame_err    out  1         one-cycle pulse: bad stop bit (or bad parity) detected
// BEHAVIOUR
//   Reset values: all outputs 0; Rx synchroniser = 1; FSM = IDLE; byte_cnt = 0.
//   Rx_Serial passes through a 2-FF synchroniser; all references below are to the synchronised value.
//   Receive FSM:
//     IDLE   entered with bit counter = 0. On en=1 and Rx=0: go to START.
//     START  wait CLKS_PER_BIT/2 cycles, then sample Rx. If Rx=1, treat as a glitch and return to IDLE. Otherwise go to DATA.
//     DATA   sample every CLKS_PER_BIT cycles, 8 bits, LSB first. After bit 7: go to PARITY (if compiled in) or STOP.
//     PARITY one sample after CLKS_PER_BIT cycles; the result is held for the STOP check.
//     STOP   sample after CLKS_PER_BIT cycles.
//            Rx=1 (and parity ok): byte accepted.
//            Otherwise: frame_err pulses for 1 cycle and the byte is discarded; byte_cnt is unchanged.
//            Either way, return to IDLE on the next cycle.
//   Word assembly is little-endian: byte k goes to recv_data[8k+7:8k]. The other recv_data bits hold until the word completes.
//   When the 4th byte is accepted:
//     - on_received=1 for exactly 1 cycle, in the cycle after the stop-bit sample.
//     - addr holds the write index during that cycle; addr increments in the following cycle.
//     - byte_cnt returns to 0.
//   Limit = latched ram_id ? DM_SIZE : IM_SIZE.
//     When the word written at addr == Limit-1 completes, the matching *_Done flag sets in the same cycle as the on_received strobe.
//     Once that flag is set, further accepted bytes are dropped: no strobe, and addr stays at Limit-1.
//   Rising edge of en:
//     - latch ram_id;
//     - addr=0, byte_cnt=0;
//     - clear the *_Done flag of the newly selected RAM only. The other flag is kept.
//   en falling edge, or en=0 mid-frame:
//     - FSM forced to IDLE within 1 cycle;
//     - any partial word is discarded; byte_cnt=0;
//     - no strobe and no frame_err.
//   ram_id changes while en=1 are ignored.
//   Asynchronous reset mid-frame: everything cleared immediately, including both *_Done flags.
// CONFIGURATION
//   UART_PARITY_EN defined:
//     - frame is 8E1; an even parity bit is inserted between DATA and STOP;
//     - a parity mismatch pulses frame_err and drops the byte, exactly like a bad stop bit.
//   UART_PARITY_EN undefined: frame is 8N1 and the PARITY state is not built.
// TESTING (bench uses CLKS_PER_BIT=16, IM_SIZE=4, DM_SIZE=8)
//   1. Assert reset mid-stream -> all outputs 0 immediately; after release, the next valid frame is received normally.
//   2. en=1, ram_id=0; send 0x78,0x56,0x34,0x12 -> single on_received with recv_data=0x12345678, addr=0; addr=1 one cycle later.
//   3. ram_id=0; send 5 words -> strobes at addr 0..3, IM_Done=1 with the 4th strobe, 5th word produces no strobe.
//      Then re-en with ram_id=1 -> DM_Done=0 and IM_Done stays 1.
//   4. Send byte 0xAA with stop bit 0 -> frame_err pulse, byte dropped; the word completes only after 4 good bytes.
//   5. Drive Rx low for 3 clocks -> no byte and no frame_err. Send 2 bytes, drop en, re-enable, send 4 bytes -> strobe at addr=0 with the new 4 bytes only.
//   6. With UART_PARITY_EN: 0x01 sent with parity 0 -> frame_err pulse, dropped; 0x03 with parity 0 -> accepted.

Source files
------------

// File: rtl/uart_word_loader.sv
// UART boot-loader receiver: 8N1 frames (8E1 when UART_PARITY_EN is defined) are packed
// little-endian into 32-bit words and written to IM or DM through a one-cycle strobe.
module uart_word_loader #(
  parameter int CLKS_PER_BIT = 868,
  parameter int IM_SIZE      = 256,
  parameter int DM_SIZE      = 512,
  parameter int ADDR_BIT     = 9
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                en,
  input  logic                ram_id,
  input  logic                Rx_Serial,
  output logic [ADDR_BIT-1:0] addr,
  output logic                on_received,
  output logic [31:0]         recv_data,
  output logic                IM_Done,
  output logic                DM_Done,
  output logic                frame_err,
  output logic [2:0]          dbg_state_o
);
  localparam int CW = $clog2(CLKS_PER_BIT + 1);
  localparam logic [CW-1:0]       FULL_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0]       HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [ADDR_BIT-1:0] IM_LAST   = ADDR_BIT'(IM_SIZE - 1);
  localparam logic [ADDR_BIT-1:0] DM_LAST   = ADDR_BIT'(DM_SIZE - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
`ifdef UART_PARITY_EN
    S_PARITY = 3'd3,
`endif
    S_STOP   = 3'd4
  } state_t;

  state_t              state_q, state_d;
  logic                rx_meta_q, rx_q, en_q;
  logic [CW-1:0]       cnt_q;
  logic [2:0]          bit_idx_q;
  logic [7:0]          shift_q;
  logic                ram_sel_q;
  logic [1:0]          byte_cnt_q;
  logic [ADDR_BIT-1:0] addr_q;
  logic [31:0]         recv_q;
  logic                strobe_q, im_done_q, dm_done_q, ferr_q;
  logic                tick, data_tick, stop_tick, byte_ok, byte_bad, par_ok;
  logic                sel_done;
  logic [ADDR_BIT-1:0] last_addr;

  assign sel_done  = ram_sel_q ? dm_done_q : im_done_q;
  assign last_addr = ram_sel_q ? DM_LAST : IM_LAST;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (!en) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE:   if (!rx_q) state_d = S_START;
        S_START:  if (tick) state_d = rx_q ? S_IDLE : S_DATA;
`ifdef UART_PARITY_EN
        S_DATA:   if (tick && bit_idx_q == 3'd7) state_d = S_PARITY;
        S_PARITY: if (tick) state_d = S_STOP;
`else
        S_DATA:   if (tick && bit_idx_q == 3'd7) state_d = S_STOP;
`endif
        S_STOP:   if (tick) state_d = S_IDLE;
        default:  state_d = S_IDLE;
      endcase
    end
  end

  // START waits half a bit so every later sample lands mid-bit.
  always_comb begin
    tick        = (state_q == S_START) ? (cnt_q == HALF_LAST)
                                       : (state_q != S_IDLE && cnt_q == FULL_LAST);
    data_tick   = tick && (state_q == S_DATA);
    stop_tick   = tick && (state_q == S_STOP);
    byte_ok     = en && stop_tick && rx_q && par_ok;
    byte_bad    = en && stop_tick && !(rx_q && par_ok);
    dbg_state_o = state_q;
  end

`ifdef UART_PARITY_EN
  logic par_ok_q;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) par_ok_q <= 1'b1;
    else if (tick && state_q == S_PARITY) par_ok_q <= ((^shift_q) == rx_q);
  end
  assign par_ok = par_ok_q;
`else
  assign par_ok = 1'b1;
`endif

  // on_received is a bare write strobe: no ready, the memory must accept it in that cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_meta_q  <= 1'b1;
      rx_q       <= 1'b1;
      en_q       <= 1'b0;
      cnt_q      <= '0;
      bit_idx_q  <= '0;
      shift_q    <= '0;
      ram_sel_q  <= 1'b0;
      byte_cnt_q <= '0;
      addr_q     <= '0;
      recv_q     <= '0;
      strobe_q   <= 1'b0;
      im_done_q  <= 1'b0;
      dm_done_q  <= 1'b0;
      ferr_q     <= 1'b0;
    end else begin
      rx_meta_q <= Rx_Serial;
      rx_q      <= rx_meta_q;
      en_q      <= en;
      cnt_q     <= (state_q == S_IDLE || tick) ? '0 : cnt_q + CW'(1);
      if (state_q == S_IDLE)  bit_idx_q <= '0;
      else if (data_tick)     bit_idx_q <= bit_idx_q + 3'd1;
      if (data_tick) shift_q <= {rx_q, shift_q[7:1]};
      strobe_q <= 1'b0;
      ferr_q   <= byte_bad;
      if (strobe_q && addr_q != last_addr) addr_q <= addr_q + ADDR_BIT'(1);
      if (en && !en_q) begin
        ram_sel_q  <= ram_id;
        addr_q     <= '0;
        byte_cnt_q <= '0;
        if (ram_id) dm_done_q <= 1'b0;
        else        im_done_q <= 1'b0;
      end else if (!en) begin
        byte_cnt_q <= '0;
      end else if (byte_ok && !sel_done) begin
        recv_q[{byte_cnt_q, 3'b000} +: 8] <= shift_q;
        byte_cnt_q <= byte_cnt_q + 2'd1;
        if (byte_cnt_q == 2'd3) begin
          strobe_q <= 1'b1;
          if (addr_q == last_addr) begin
            if (ram_sel_q) dm_done_q <= 1'b1;
            else           im_done_q <= 1'b1;
          end
        end
      end
    end
  end

  assign addr        = addr_q;
  assign on_received = strobe_q;
  assign recv_data   = recv_q;
  assign IM_Done     = im_done_q;
  assign DM_Done     = dm_done_q;
  assign frame_err   = ferr_q;
endmodule

// File: tb/tb_uart_word_loader.sv
// Directed bench for uart_word_loader (CLKS_PER_BIT=16, IM_SIZE=4, DM_SIZE=8);
// parity vectors are added when UART_PARITY_EN is defined.
module tb_uart_word_loader;
  localparam int CPB = 16;
  localparam int AW  = 4;

  logic          clk = 1'b0;
  logic          reset, en, ram_id, Rx_Serial;
  logic [AW-1:0] addr;
  logic          on_received, IM_Done, DM_Done, frame_err;
  logic [31:0]   recv_data;
  logic [2:0]    dbg_state;

  uart_word_loader #(.CLKS_PER_BIT(CPB), .IM_SIZE(4), .DM_SIZE(8), .ADDR_BIT(AW)) dut (
    .clk(clk), .reset(reset), .en(en), .ram_id(ram_id), .Rx_Serial(Rx_Serial),
    .addr(addr), .on_received(on_received), .recv_data(recv_data),
    .IM_Done(IM_Done), .DM_Done(DM_Done), .frame_err(frame_err), .dbg_state_o(dbg_state)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Expected word entry: {done{IM,DM}[41:40], next_addr[39:36], addr[35:32], data[31:0]}
  logic [41:0]   exp_q[$];
  int            strobe_cnt = 0;
  int            fe_cnt     = 0;
  logic          nxt_pending = 1'b0;
  logic [AW-1:0] nxt_addr;

  always @(negedge clk) begin
    logic [41:0] e;
    if (nxt_pending) begin
      check_eq("addr_after_strobe", addr, nxt_addr);
      check_eq("strobe_width", on_received, 1'b0);
      nxt_pending = 1'b0;
    end
    if (frame_err) fe_cnt++;
    if (on_received) begin
      strobe_cnt++;
      if (exp_q.size() == 0) begin
        check_eq("unexpected_strobe", on_received, 1'b0);
      end else begin
        e = exp_q.pop_front();
        check_eq("word_data", recv_data, e[31:0]);
        check_eq("word_addr", addr, e[35:32]);
        check_eq("word_done", {IM_Done, DM_Done}, e[41:40]);
        nxt_addr    = e[39:36];
        nxt_pending = 1'b1;
      end
    end
  end

  task automatic push_word(input logic [31:0] d, input int a, input int nxt, input logic [1:0] done);
    exp_q.push_back({done, 4'(nxt), 4'(a), d});
  endtask

  task automatic send_byte(input logic [7:0] d, input logic stop_b, input logic par_b);
    Rx_Serial = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      Rx_Serial = d[i];
      repeat (CPB) @(negedge clk);
    end
`ifdef UART_PARITY_EN
    Rx_Serial = par_b;
    repeat (CPB) @(negedge clk);
`else
    if (par_b === 1'bx) Rx_Serial = 1'b1;
`endif
    Rx_Serial = stop_b;
    repeat (CPB) @(negedge clk);
    Rx_Serial = 1'b1;
    repeat (20) @(negedge clk);
  endtask

  task automatic send_good(input logic [7:0] d);
    send_byte(d, 1'b1, ^d);
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 0; i < 4; i++) send_good(w[8*i +: 8]);
  endtask

  task automatic restart(input logic r);
    en = 1'b0;
    repeat (4) @(negedge clk);
    ram_id = r;
    en = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic check_zero(input string tag);
    check_eq({tag, "_addr"}, addr, 0);
    check_eq({tag, "_strobe"}, on_received, 0);
    check_eq({tag, "_data"}, recv_data, 0);
    check_eq({tag, "_im_done"}, IM_Done, 0);
    check_eq({tag, "_dm_done"}, DM_Done, 0);
    check_eq({tag, "_ferr"}, frame_err, 0);
    check_eq({tag, "_state"}, dbg_state, 0);
  endtask

  initial begin
    int s0, f0;
    logic [31:0] w;
    reset = 1'b1; en = 1'b0; ram_id = 1'b0; Rx_Serial = 1'b1;
    repeat (3) @(negedge clk);
    check_zero("rst_init");
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // Single word into IM
    en = 1'b1; ram_id = 1'b0;
    repeat (2) @(negedge clk);
    push_word(32'h12345678, 0, 1, 2'b00);
    send_word(32'h12345678);
    check_eq("t2_strobes", strobe_cnt, 1);
    check_eq("t2_addr", addr, 1);

    // Fill IM, overflow word is dropped
    restart(1'b0);
    check_eq("t3_addr0", addr, 0);
    s0 = strobe_cnt;
    for (int k = 0; k < 5; k++) begin
      w = 32'hA1B2C3D4 ^ 32'(32'h01010101 * k);
      if (k < 4) push_word(w, k, (k < 3) ? k + 1 : 3, (k == 3) ? 2'b10 : 2'b00);
      send_word(w);
      if (k == 2) check_eq("t3_im_done_early", IM_Done, 0);
    end
    check_eq("t3_strobes", strobe_cnt, s0 + 4);
    check_eq("t3_im_done", IM_Done, 1);
    check_eq("t3_addr_hold", addr, 3);

    // Switch to DM: only the DM flag clears; ram_id changes mid-load are ignored
    restart(1'b1);
    check_eq("t3_dm_clear", DM_Done, 0);
    check_eq("t3_im_kept", IM_Done, 1);
    check_eq("t3_dm_addr0", addr, 0);
    s0 = strobe_cnt;
    for (int k = 0; k < 8; k++) begin
      w = 32'h0F1E2D3C + 32'(32'h00100001 * k);
      push_word(w, k, (k < 7) ? k + 1 : 7, (k == 7) ? 2'b11 : 2'b10);
      send_word(w);
      if (k == 0) ram_id = 1'b0;
    end
    check_eq("dm_strobes", strobe_cnt, s0 + 8);
    check_eq("dm_done", DM_Done, 1);
    restart(1'b0);
    check_eq("im_reclear", IM_Done, 0);
    check_eq("dm_kept", DM_Done, 1);

    // Asynchronous reset in the middle of a frame
    fork
      send_good(8'h5A);
      begin
        repeat (60) @(negedge clk);
        #2 reset = 1'b1;
        #1 check_zero("rst_mid");
      end
    join
    reset = 1'b0;
    repeat (2) @(negedge clk);
    s0 = strobe_cnt;
    push_word(32'hCAFEF00D, 0, 1, 2'b00);
    send_word(32'hCAFEF00D);
    check_eq("rst_recover", strobe_cnt, s0 + 1);

    // Bad stop bit drops one byte only
    restart(1'b0);
    s0 = strobe_cnt; f0 = fe_cnt;
    push_word(32'h44332211, 0, 1, 2'b00);
    send_good(8'h11);
    send_byte(8'hAA, 1'b0, ^8'hAA);
    check_eq("t4_ferr", fe_cnt, f0 + 1);
    send_good(8'h22);
    send_good(8'h33);
    check_eq("t4_no_early_word", strobe_cnt, s0);
    send_good(8'h44);
    check_eq("t4_word", strobe_cnt, s0 + 1);

    // Start-bit glitch, then a partial word abandoned by dropping en mid-frame
    s0 = strobe_cnt; f0 = fe_cnt;
    Rx_Serial = 1'b0;
    repeat (3) @(negedge clk);
    Rx_Serial = 1'b1;
    repeat (30) @(negedge clk);
    check_eq("t5_glitch_ferr", fe_cnt, f0);
    check_eq("t5_glitch_idle", dbg_state, 0);
    send_good(8'h01);
    send_good(8'h02);
    fork
      send_good(8'h03);
      begin
        repeat (60) @(negedge clk);
        en = 1'b0;
        repeat (2) @(negedge clk);
        check_eq("t5_forced_idle", dbg_state, 0);
      end
    join
    check_eq("t5_en_drop_ferr", fe_cnt, f0);
    check_eq("t5_en_drop_strobe", strobe_cnt, s0);
    restart(1'b0);
    push_word(32'hDDCCBBAA, 0, 1, 2'b00);
    send_word(32'hDDCCBBAA);
    check_eq("t5_new_word", strobe_cnt, s0 + 1);

`ifdef UART_PARITY_EN
    restart(1'b0);
    s0 = strobe_cnt; f0 = fe_cnt;
    send_byte(8'h01, 1'b1, 1'b0);
    check_eq("par_bad_ferr", fe_cnt, f0 + 1);
    push_word(32'h09070503, 0, 1, 2'b00);
    send_byte(8'h03, 1'b1, 1'b0);
    send_good(8'h05);
    send_good(8'h07);
    send_good(8'h09);
    check_eq("par_ok_ferr", fe_cnt, f0 + 1);
    check_eq("par_word", strobe_cnt, s0 + 1);
`endif

    repeat (4) @(negedge clk);
    check_eq("exp_q_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
